clap_detector: RTL and testbench



---
 rtl/clap_pkg.sv | 17 +
 rtl/clap_average.sv | 38 +++
 rtl/clap_detector.sv | 140 ++++++++++++++
 tb/tb_clap_detector.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clap_pkg.sv
// Shared encodings for the clap detector: pair-recognition states and
// handshake phases.
package clap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD1 = 2'd1,
    WAIT2 = 2'd2,
    HOLD2 = 2'd3
  } state_e;

  typedef enum logic {
    ACCEPT   = 1'b0,
    EVALUATE = 1'b1
  } phase_e;

endpackage

// File: rtl/clap_average.sv
// Running-average background energy with clap threshold compare; the average
// only moves when the caller enables an update.
module clap_average #(
  parameter int ENERGY_WIDTH = 32,
  parameter int AVG_SHIFT    = 4,
  parameter int THRESH_SHIFT = 2,
  parameter int MIN_ENERGY   = 1024,
  parameter int INIT_AVG     = 256
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ENERGY_WIDTH-1:0] sample_i,
  input  logic                    update_i,
  output logic                    is_clap_o
);

  localparam int CW = ENERGY_WIDTH + THRESH_SHIFT;

  logic [ENERGY_WIDTH-1:0] avg_q, avg_d;
  logic [CW-1:0]           thresh;
  logic [CW-1:0]           sample_wide;

  // Widened so the scaled average can never wrap below the sample.
  assign thresh      = CW'(avg_q) << THRESH_SHIFT;
  assign sample_wide = CW'(sample_i);
  assign is_clap_o   = (sample_i >= ENERGY_WIDTH'(MIN_ENERGY)) && (sample_wide > thresh);

  assign avg_d = avg_q + (sample_i >> AVG_SHIFT) - (avg_q >> AVG_SHIFT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      avg_q <= ENERGY_WIDTH'(INIT_AVG);
    end else if (update_i) begin
      avg_q <= avg_d;
    end
  end

endmodule

// File: rtl/clap_detector.sv
// Double-clap detector: accepts energy samples, flags claps against the
// background average and toggles the light on each recognised pair.
module clap_detector
  import clap_pkg::*;
#(
  parameter int ENERGY_WIDTH = 32,
  parameter int AVG_SHIFT    = 4,
  parameter int THRESH_SHIFT = 2,
  parameter int MIN_ENERGY   = 1024,
  parameter int INIT_AVG     = 256,
  parameter int HOLDOFF      = 4,
  parameter int WINDOW       = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic                    energy_valid,
  output logic                    energy_ready,
  output logic                    clap_pulse,
  output logic                    double_pulse,
  output logic                    light
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int WW = $clog2(WINDOW + 1);

  phase_e                  phase_q, phase_d;
  state_e                  state_q, state_d;
  logic                    run_q;
  logic [ENERGY_WIDTH-1:0] data_q;
  logic [HW-1:0]           hold_q, hold_d;
  logic [WW-1:0]           win_q, win_d;
  logic                    clap_q, clap_d;
  logic                    dbl_q, dbl_d;
  logic                    light_q, light_d;

  logic transfer, evaluate, in_hold, is_clap, avg_update;

  assign energy_ready = run_q && (phase_q == ACCEPT);
  assign transfer     = energy_valid && energy_ready;
  assign evaluate     = (phase_q == EVALUATE);
  assign in_hold      = (state_q == HOLD1) || (state_q == HOLD2);
  assign avg_update   = evaluate && !in_hold && !is_clap;
  assign phase_d      = transfer ? EVALUATE : ACCEPT;

  assign clap_pulse   = clap_q;
  assign double_pulse = dbl_q;
  assign light        = light_q;

  clap_average #(
    .ENERGY_WIDTH (ENERGY_WIDTH),
    .AVG_SHIFT    (AVG_SHIFT),
    .THRESH_SHIFT (THRESH_SHIFT),
    .MIN_ENERGY   (MIN_ENERGY),
    .INIT_AVG     (INIT_AVG)
  ) u_avg (
    .clock     (clock),
    .resetn    (resetn),
    .sample_i  (data_q),
    .update_i  (avg_update),
    .is_clap_o (is_clap)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q <= ACCEPT;
      state_q <= IDLE;
      run_q   <= 1'b0;
      data_q  <= '0;
      hold_q  <= '0;
      win_q   <= '0;
      clap_q  <= 1'b0;
      dbl_q   <= 1'b0;
      light_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      run_q   <= 1'b1;
      if (transfer) begin
        data_q <= energy_data;
      end
      hold_q  <= hold_d;
      win_q   <= win_d;
      clap_q  <= clap_d;
      dbl_q   <= dbl_d;
      light_q <= light_d;
    end
  end

  // The pair FSM only moves in the cycle that evaluates a captured sample.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    win_d   = win_q;
    clap_d  = 1'b0;
    dbl_d   = 1'b0;
    light_d = light_q;
    if (evaluate) begin
      case (state_q)
        IDLE: begin
          if (is_clap) begin
            clap_d  = 1'b1;
            hold_d  = HW'(HOLDOFF);
            state_d = HOLD1;
          end
        end
        HOLD1, HOLD2: begin
          if (hold_q <= HW'(1)) begin
            hold_d = '0;
            if (state_q == HOLD1) begin
              win_d   = WW'(WINDOW);
              state_d = WAIT2;
            end else begin
              state_d = IDLE;
            end
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        WAIT2: begin
          // A clap on the final window sample still completes the pair.
          if (is_clap) begin
            clap_d  = 1'b1;
            dbl_d   = 1'b1;
            light_d = ~light_q;
            hold_d  = HW'(HOLDOFF);
            state_d = HOLD2;
          end else if (win_q <= WW'(1)) begin
            win_d   = '0;
            state_d = IDLE;
          end else begin
            win_d = win_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clap_detector.sv
// Directed bench for clap_detector: reset, threshold, timeout, double clap
// and back-to-back handshake scenarios.
module tb_clap_detector;
  import clap_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        energy_valid = 1'b0;
  logic [31:0] energy_data = '0;
  logic        energy_ready, clap_pulse, double_pulse, light;
  logic        lo_ready, lo_clap, lo_double, lo_light;

  int checks = 0;
  int failures = 0;
  int clap_seen = 0;
  int xfer_seen = 0;
  logic last_cp, last_dp, last_lt, last_lo_cp;

  always #5 clock = ~clock;

  clap_detector dut (
    .clock        (clock),
    .resetn       (resetn),
    .energy_data  (energy_data),
    .energy_valid (energy_valid),
    .energy_ready (energy_ready),
    .clap_pulse   (clap_pulse),
    .double_pulse (double_pulse),
    .light        (light)
  );

  clap_detector #(.INIT_AVG(100)) dut_lo (
    .clock        (clock),
    .resetn       (resetn),
    .energy_data  (energy_data),
    .energy_valid (energy_valid),
    .energy_ready (lo_ready),
    .clap_pulse   (lo_clap),
    .double_pulse (lo_double),
    .light        (lo_light)
  );

  always @(negedge clock) if (resetn && clap_pulse) clap_seen++;
  always @(posedge clock) if (energy_valid && energy_ready) xfer_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the evaluate edge.
  task automatic send(input logic [31:0] e);
    int n;
    n = 0;
    energy_data  = e;
    energy_valid = 1'b1;
    while (!energy_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (energy_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout got=%0b want=1", energy_ready);
    end
    @(negedge clock);
    energy_valid = 1'b0;
    @(negedge clock);
    last_cp    = clap_pulse;
    last_dp    = double_pulse;
    last_lt    = light;
    last_lo_cp = lo_clap;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn       = 1'b0;
    energy_valid = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    int x0;
    @(negedge clock);
    resetn       = 1'b0;
    energy_valid = 1'b1;
    energy_data  = 32'd5000;
    x0 = xfer_seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (energy_ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready cycle=%0d got=%0b want=0", i, energy_ready);
      end
      checks++;
      if (light !== 1'b0) begin
        failures++; $display("FAIL reset_light cycle=%0d got=%0b want=0", i, light);
      end
    end
    checks++;
    if (xfer_seen !== x0) begin
      failures++; $display("FAIL reset_no_transfer got=%0d want=%0d", xfer_seen, x0);
    end
    energy_valid = 1'b0;
    resetn = 1'b1;
    #1;
    checks++;
    if (energy_ready !== 1'b0) begin
      failures++; $display("FAIL ready_before_clock got=%0b want=0", energy_ready);
    end
    @(negedge clock);
    checks++;
    if (energy_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_release got=%0b want=1", energy_ready);
    end
    checks++;
    if (clap_pulse !== 1'b0 || double_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got=%0b%0b want=00", clap_pulse, double_pulse);
    end
    checks++;
    if (dut.u_avg.avg_q !== 32'd256) begin
      failures++; $display("FAIL reset_avg got=%0d want=256", dut.u_avg.avg_q);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_steady();
    for (int i = 0; i < 20; i++) begin
      send(32'd256);
      checks++;
      if (last_cp !== 1'b0 || last_dp !== 1'b0 || last_lt !== 1'b0) begin
        failures++;
        $display("FAIL steady_outputs sample=%0d got=%0b%0b%0b want=000", i, last_cp, last_dp, last_lt);
      end
    end
    checks++;
    if (dut.u_avg.avg_q !== 32'd256) begin
      failures++; $display("FAIL steady_avg got=%0d want=256", dut.u_avg.avg_q);
    end
  endtask

  task automatic test_threshold();
    send(32'd1024);
    checks++;
    if (last_cp !== 1'b0) begin
      failures++; $display("FAIL thr_1024_clap got=%0b want=0", last_cp);
    end
    checks++;
    if (dut.u_avg.avg_q !== 32'd304) begin
      failures++; $display("FAIL thr_1024_avg got=%0d want=304", dut.u_avg.avg_q);
    end
    do_reset();
    send(32'd1025);
    checks++;
    if (last_cp !== 1'b1) begin
      failures++; $display("FAIL thr_1025_clap got=%0b want=1", last_cp);
    end
    do_reset();
    send(32'd1023);
    checks++;
    if (last_lo_cp !== 1'b0) begin
      failures++; $display("FAIL thr_lo_1023_clap got=%0b want=0", last_lo_cp);
    end
    checks++;
    if (dut_lo.u_avg.avg_q !== 32'd157) begin
      failures++; $display("FAIL thr_lo_avg got=%0d want=157", dut_lo.u_avg.avg_q);
    end
    checks++;
    if (dut.u_avg.avg_q !== 32'd303) begin
      failures++; $display("FAIL thr_1023_avg got=%0d want=303", dut.u_avg.avg_q);
    end
    send(32'd1024);
    checks++;
    if (last_lo_cp !== 1'b1) begin
      failures++; $display("FAIL thr_lo_1024_clap got=%0b want=1", last_lo_cp);
    end
    checks++;
    if (last_cp !== 1'b0) begin
      failures++; $display("FAIL thr_303_1024_clap got=%0b want=0", last_cp);
    end
  endtask

  task automatic test_single_timeout();
    int c0;
    do_reset();
    send(32'd256);
    send(32'd256);
    c0 = clap_seen;
    send(32'd5000);
    checks++;
    if (last_cp !== 1'b1 || last_dp !== 1'b0) begin
      failures++; $display("FAIL single_first got=%0b%0b want=10", last_cp, last_dp);
    end
    for (int i = 0; i < 35; i++) send(32'd256);
    checks++;
    if (dut.state_q !== WAIT2) begin
      failures++; $display("FAIL single_window_open got=%0d want=%0d", dut.state_q, WAIT2);
    end
    send(32'd256);
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++; $display("FAIL single_timeout_state got=%0d want=%0d", dut.state_q, IDLE);
    end
    for (int i = 0; i < 4; i++) send(32'd256);
    checks++;
    if (clap_seen - c0 !== 1) begin
      failures++; $display("FAIL single_clap_count got=%0d want=1", clap_seen - c0);
    end
    checks++;
    if (light !== 1'b0) begin
      failures++; $display("FAIL single_light got=%0b want=0", light);
    end
    send(32'd5000);
    checks++;
    if (last_cp !== 1'b1 || last_dp !== 1'b0 || last_lt !== 1'b0) begin
      failures++; $display("FAIL single_later got=%0b%0b%0b want=100", last_cp, last_dp, last_lt);
    end
  endtask

  task automatic test_double();
    logic exp_lt;
    do_reset();
    send(32'd256);
    for (int r = 0; r < 2; r++) begin
      exp_lt = (r == 0);
      send(32'd5000);
      checks++;
      if (last_cp !== 1'b1 || last_dp !== 1'b0) begin
        failures++; $display("FAIL double_first round=%0d got=%0b%0b want=10", r, last_cp, last_dp);
      end
      send(32'd5000);
      checks++;
      if (last_cp !== 1'b0) begin
        failures++; $display("FAIL double_holdoff_ignored round=%0d got=%0b want=0", r, last_cp);
      end
      for (int i = 0; i < 3; i++) begin
        send(32'd256);
        checks++;
        if (last_cp !== 1'b0) begin
          failures++; $display("FAIL double_filler round=%0d got=%0b want=0", r, last_cp);
        end
      end
      send(32'd5000);
      checks++;
      if (last_cp !== 1'b1 || last_dp !== 1'b1 || last_lt !== exp_lt) begin
        failures++;
        $display("FAIL double_second round=%0d got=%0b%0b%0b want=11%0b", r, last_cp, last_dp, last_lt, exp_lt);
      end
      for (int i = 0; i < 4; i++) send(32'd256);
      checks++;
      if (dut.state_q !== IDLE) begin
        failures++; $display("FAIL double_hold2_exit round=%0d got=%0d want=%0d", r, dut.state_q, IDLE);
      end
    end
  endtask

  task automatic test_back_to_back();
    int x0;
    logic exp_rdy;
    do_reset();
    x0 = xfer_seen;
    energy_data  = 32'd256;
    energy_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_rdy = ((i % 2) == 0);
      checks++;
      if (energy_ready !== exp_rdy) begin
        failures++; $display("FAIL b2b_ready cycle=%0d got=%0b want=%0b", i, energy_ready, exp_rdy);
      end
      @(negedge clock);
    end
    energy_valid = 1'b0;
    checks++;
    if (xfer_seen - x0 !== 6) begin
      failures++; $display("FAIL b2b_transfers got=%0d want=6", xfer_seen - x0);
    end
    checks++;
    if (dut.u_avg.avg_q !== 32'd256) begin
      failures++; $display("FAIL b2b_avg got=%0d want=256", dut.u_avg.avg_q);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'd256);
    send(32'd5000);
    for (int i = 0; i < 4; i++) send(32'd256);
    send(32'd5000);
    for (int i = 0; i < 4; i++) send(32'd256);
    send(32'd5000);
    for (int i = 0; i < 4; i++) send(32'd256);
    checks++;
    if (dut.state_q !== WAIT2 || light !== 1'b1) begin
      failures++; $display("FAIL mid_setup state=%0d light=%0b want state=%0d light=1", dut.state_q, light, WAIT2);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (light !== 1'b0) begin
      failures++; $display("FAIL mid_reset_light got=%0b want=0", light);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++; $display("FAIL mid_reset_state got=%0d want=%0d", dut.state_q, IDLE);
    end
    checks++;
    if (energy_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ready got=%0b want=0", energy_ready);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_threshold();
    test_single_timeout();
    test_double();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
